// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, field positions and exception codes for coprocessor 0.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR field positions
    localparam int SR_IM_HI = 15;
    localparam int SR_IM_LO = 10;
    localparam int SR_EXL   = 1;
    localparam int SR_IE    = 0;

    // Cause field positions
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_EC_HI = 6;
    localparam int CAUSE_EC_LO = 2;

    // Exception codes
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0.sv
// cp0: MIPS32 coprocessor 0 holding SR, Cause, EPC and PRId; raises intreq
// for unmasked interrupts and pending exceptions and records exception entry.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] Din,
    input  logic [31:2] PC,
    input  logic [6:2]  ExcCode,
    input  logic [5:0]  HW,
    input  logic        we,
    input  logic        Exlset,
    input  logic        Exlclr,
    input  logic        BD,
    output logic        intreq,
    output logic [31:0] EPC_out,
    output logic [31:0] Dout
);

    // Architectural state; only the implemented fields are stored.
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:2] r_epc;

    logic        w_int_pend;
    logic        w_exc_pend;
    logic [31:0] w_pc_byte;
    logic [31:0] w_epc_next;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    // Request evaluation is purely combinational so the pipeline sees it this cycle.
    assign w_int_pend = (|(HW & r_im)) & r_ie & ~r_exl;
    assign w_exc_pend = (ExcCode != 5'd0) & ~r_exl;
    assign intreq     = w_int_pend | w_exc_pend;

    // A delay-slot victim restarts at the branch, one word earlier.
    assign w_pc_byte  = {PC, 2'b00};
    assign w_epc_next = BD ? (w_pc_byte - 32'd4) : w_pc_byte;

    always_comb begin
        w_sr = 32'd0;
        w_sr[SR_IM_HI:SR_IM_LO] = r_im;
        w_sr[SR_EXL]            = r_exl;
        w_sr[SR_IE]             = r_ie;
    end

    always_comb begin
        w_cause = 32'd0;
        w_cause[CAUSE_BD]                = r_bd;
        w_cause[CAUSE_IP_HI:CAUSE_IP_LO] = r_ip;
        w_cause[CAUSE_EC_HI:CAUSE_EC_LO] = r_exccode;
    end

    assign EPC_out = {r_epc, 2'b00};

    // mfc0 read mux; unimplemented register numbers read as zero.
    always_comb begin
        Dout = 32'd0;
        case (A1)
            REG_SR:    Dout = w_sr;
            REG_CAUSE: Dout = w_cause;
            REG_EPC:   Dout = {r_epc, 2'b00};
            REG_PRID:  Dout = PRID;
            default:   Dout = 32'd0;
        endcase
    end

    // State update: reset > exception entry > eret > mtc0; eret after mtc0 so EXL ends at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= 6'd0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'd0;
            r_exccode <= 5'd0;
            r_epc     <= 30'd0;
        end else begin
            r_ip <= HW;
            if (Exlset) begin
                r_exl     <= 1'b1;
                r_bd      <= BD;
                r_exccode <= w_int_pend ? EXC_INT : ExcCode;
                r_epc     <= w_epc_next[31:2];
            end else begin
                if (we && (A2 == REG_SR)) begin
                    r_im  <= Din[SR_IM_HI:SR_IM_LO];
                    r_exl <= Din[SR_EXL];
                    r_ie  <= Din[SR_IE];
                end
                if (we && (A2 == REG_EPC)) begin
                    r_epc <= Din[31:2];
                end
                if (Exlclr) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed vectors for cp0. Each vector is driven on the falling edge,
// outputs are compared shortly after (state from earlier edges, current inputs),
// then the rising edge commits the vector.
module tb_cp0;

    localparam logic [31:0] TB_PRID = 32'h0001_8000;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] Din;
    logic [31:2] PC;
    logic [6:2]  ExcCode;
    logic [5:0]  HW;
    logic        we, Exlset, Exlclr, BD;
    logic        intreq;
    logic [31:0] EPC_out, Dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0 #(.PRID(TB_PRID)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .PC(PC),
        .ExcCode(ExcCode), .HW(HW), .we(we), .Exlset(Exlset), .Exlclr(Exlclr),
        .BD(BD), .intreq(intreq), .EPC_out(EPC_out), .Dout(Dout)
    );

    typedef struct {
        logic        rst, we, set, clr, bd;
        logic [4:0]  a1, a2;
        logic [31:0] din;
        logic [29:0] pc;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        e_int;
        logic [31:0] e_epc, e_dout;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic w, input logic set,
                                input logic clr, input logic bd, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [31:0] din,
                                input logic [29:0] pc, input logic [4:0] exc,
                                input logic [5:0] hw, input logic e_int,
                                input logic [31:0] e_epc, input logic [31:0] e_dout);
        vec_t v;
        v.rst = rst; v.we = w; v.set = set; v.clr = clr; v.bd = bd;
        v.a1 = a1; v.a2 = a2; v.din = din; v.pc = pc; v.exc = exc; v.hw = hw;
        v.e_int = e_int; v.e_epc = e_epc; v.e_dout = e_dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; we = v.we; Exlset = v.set; Exlclr = v.clr; BD = v.bd;
        A1 = v.a1; A2 = v.a2; Din = v.din; PC = v.pc; ExcCode = v.exc; HW = v.hw;
    endtask

    vec_t tv[40];

    initial begin
        //          rst we set clr bd  a1  a2  din            pc        exc  hw     int  epc            dout
        tv[0]  = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h0,         32'h0);
        tv[1]  = mk(0, 0, 0, 0, 0, 13, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h0,         32'h0);
        tv[2]  = mk(0, 0, 0, 0, 0, 14, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h0,         32'h0);
        tv[3]  = mk(0, 1, 0, 0, 0, 12, 12, 32'h0000_FC03, 30'h0,    0,  6'd0, 0, 32'h0,         32'h0);
        tv[4]  = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h0,         32'h0000_FC03);
        tv[5]  = mk(0, 1, 0, 0, 0, 14, 14, 32'h0000_3007, 30'h0,    0,  6'd0, 0, 32'h0,         32'h0);
        tv[6]  = mk(0, 0, 0, 0, 0, 14, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3004,      32'h3004);
        tv[7]  = mk(0, 1, 0, 0, 0, 13, 13, 32'hFFFF_FFFF, 30'h0,    0,  6'd0, 0, 32'h3004,      32'h0);
        tv[8]  = mk(0, 0, 0, 0, 0, 13, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3004,      32'h0);
        // hardware interrupt and entry
        tv[9]  = mk(0, 1, 0, 0, 0, 12, 12, 32'h0000_0401, 30'h0,    0,  6'd0, 0, 32'h3004,      32'h0000_FC03);
        tv[10] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd1, 1, 32'h3004,      32'h0000_0401);
        tv[11] = mk(0, 0, 1, 0, 0, 13, 0,  32'h0,         30'h0C01, 0,  6'd1, 1, 32'h3004,      32'h0000_0400);
        tv[12] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd1, 0, 32'h3004,      32'h0000_0403);
        tv[13] = mk(0, 0, 0, 0, 0, 13, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3004,      32'h0000_0400);
        // exception in delay slot
        tv[14] = mk(0, 1, 0, 0, 0, 12, 12, 32'h0,         30'h0,    0,  6'd0, 0, 32'h3004,      32'h0000_0403);
        tv[15] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    12, 6'd0, 1, 32'h3004,      32'h0);
        tv[16] = mk(0, 0, 1, 0, 1, 14, 0,  32'h0,         30'h0C04, 12, 6'd0, 1, 32'h3004,      32'h3004);
        tv[17] = mk(0, 0, 0, 0, 0, 13, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h300C,      32'h8000_0030);
        tv[18] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    4,  6'd0, 0, 32'h300C,      32'h0000_0002);
        // eret
        tv[19] = mk(0, 0, 0, 1, 0, 12, 0,  32'h0,         30'h0,    4,  6'd0, 0, 32'h300C,      32'h0000_0002);
        tv[20] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    4,  6'd0, 1, 32'h300C,      32'h0);
        tv[21] = mk(0, 0, 0, 0, 0, 13, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h300C,      32'h8000_0030);
        // masking
        tv[22] = mk(0, 1, 0, 0, 0, 12, 12, 32'h0000_0400, 30'h0,    0,  6'd0, 0, 32'h300C,      32'h0);
        tv[23] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd1, 0, 32'h300C,      32'h0000_0400);
        tv[24] = mk(0, 1, 0, 0, 0, 13, 12, 32'h0000_0801, 30'h0,    0,  6'd1, 0, 32'h300C,      32'h8000_0430);
        tv[25] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd1, 0, 32'h300C,      32'h0000_0801);
        tv[26] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd2, 1, 32'h300C,      32'h0000_0801);
        // Exlset with coincident mtc0 EPC
        tv[27] = mk(0, 1, 1, 0, 0, 14, 14, 32'h0000_1234, 30'h0C10, 0,  6'd2, 1, 32'h300C,      32'h300C);
        tv[28] = mk(0, 0, 0, 0, 0, 14, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3040,      32'h3040);
        tv[29] = mk(0, 0, 0, 0, 0, 13, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3040,      32'h0);
        // mtc0 SR together with eret: EXL ends cleared
        tv[30] = mk(0, 1, 0, 1, 0, 12, 12, 32'h0000_FC03, 30'h0,    0,  6'd0, 0, 32'h3040,      32'h0000_0803);
        tv[31] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3040,      32'h0000_FC01);
        tv[32] = mk(0, 0, 0, 0, 0, 15, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3040,      TB_PRID);
        tv[33] = mk(0, 0, 0, 0, 0, 3,  0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3040,      32'h0);
        // Exlset beats a coincident eret
        tv[34] = mk(0, 0, 1, 1, 0, 12, 0,  32'h0,         30'h0C20, 10, 6'd0, 1, 32'h3040,      32'h0000_FC01);
        tv[35] = mk(0, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3080,      32'h0000_FC03);
        tv[36] = mk(0, 0, 0, 0, 0, 13, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h3080,      32'h0000_0028);
        // reset in mid-run
        tv[37] = mk(1, 0, 0, 0, 0, 12, 0,  32'h0,         30'h0,    0,  6'd3, 0, 32'h3080,      32'h0000_FC03);
        tv[38] = mk(0, 0, 0, 0, 0, 14, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h0,         32'h0);
        tv[39] = mk(0, 0, 0, 0, 0, 13, 0,  32'h0,         30'h0,    0,  6'd0, 0, 32'h0,         32'h0);

        drive(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 30'h0, 0, 6'd0, 0, 32'h0, 32'h0));
        repeat (2) @(posedge clk);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("v%0d intreq", i), {31'd0, intreq}, {31'd0, tv[i].e_int});
            chk($sformatf("v%0d EPC_out", i), EPC_out, tv[i].e_epc);
            chk($sformatf("v%0d Dout", i), Dout, tv[i].e_dout);
        end

        // Interrupt and exception pending together: entry records ExcCode 0.
        @(negedge clk);
        drive(mk(0, 1, 0, 0, 0, 0, 12, 32'h0000_0401, 30'h0, 0, 6'd0, 0, 32'h0, 32'h0));
        @(negedge clk);
        drive(mk(0, 0, 1, 0, 0, 0, 0, 32'h0, 30'h0C01, 12, 6'd1, 0, 32'h0, 32'h0));
        #1;
        chk("prio intreq", {31'd0, intreq}, 32'd1);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 13, 0, 32'h0, 30'h0, 12, 6'd0, 0, 32'h0, 32'h0));
        #1;
        chk("prio cause", Dout, 32'h0000_0400);
        chk("prio epc", EPC_out, 32'h0000_3004);
        chk("prio intreq masked by EXL", {31'd0, intreq}, 32'd0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0.md
Name: cp0

Overview:
- MIPS32 coprocessor 0 for the pipelined CPU. Holds SR (reg 12), Cause (reg 13), EPC (reg 14) and PRId (reg 15).
- Evaluates hardware-interrupt and exception requests and raises `intreq` to the pipeline.
- Records exception state when the CPU commits an exception, and clears EXL on `eret`.
- Sits beside the M stage: `mfc0` reads, `mtc0` writes, exception entry and exit.

Parameters:
- PRID, 32'h0000_0000, constant value returned when register 15 is read.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears SR, Cause and EPC.
- A1  input  5  read register number for `Dout` (`mfc0`).
- A2  input  5  write register number (`mtc0`).
- Din  input  32  write data.
- PC  input  30 ([31:2])  word address of the victim instruction.
- ExcCode  input  5 ([6:2])  exception code from the pipeline; 0 means no exception.
- HW  input  6  external hardware interrupt lines HW[5:0].
- we  input  1  write enable for A2/Din.
- Exlset  input  1  CPU is entering the exception handler this cycle.
- Exlclr  input  1  `eret` commits; clear EXL.
- BD  input  1  victim instruction is in a branch delay slot.
- intreq  output  1  interrupt or exception request (combinational).
- EPC_out  output  32  current EPC value.
- Dout  output  32  read data for A1 (combinational).

Behaviour:
- SR fields: IM = SR[15:10], EXL = SR[1], IE = SR[0]. All other bits read 0.
- Cause fields: BD = Cause[31], IP = Cause[15:10], ExcCode = Cause[6:2]. All other bits read 0.
- EPC is 32 bits; bits [1:0] are always 0.
- Reset: SR, Cause and EPC become 0. Consequently `intreq` = 0 and `EPC_out` = 0. `Dout` reads 0 for regs 12–14.
- `int_pend` = |(HW & IM) & IE & ~EXL.
- `exc_pend` = (ExcCode != 0) & ~EXL.
- `intreq` = `int_pend` | `exc_pend`, purely combinational with no latency.
- Cause.IP <= HW every cycle when not in reset.
- Exlset edge:
  - EXL <= 1.
  - Cause.BD <= BD.
  - Cause.ExcCode <= 0 if `int_pend`, else ExcCode. Interrupt has priority over exception.
  - EPC <= BD ? ({PC,2'b00} - 4) : {PC,2'b00}.
- Exlclr edge (Exlset = 0): EXL <= 0. All other fields are unchanged.
- we edge (Exlset = 0):
  - A2 = 12: SR <= Din masked to IM/EXL/IE.
  - A2 = 14: EPC <= {Din[31:2],2'b00}.
  - A2 = 13, 15 or any other number: ignored (Cause and PRId are read-only).
- Priority within one edge: reset > Exlset > Exlclr > we.
  - Exlset suppresses a coincident `mtc0` and `eret`.
  - we together with Exlclr: the SR write applies first, then EXL is forced to 0.
- Read: `Dout` = SR, Cause, EPC or PRID for A1 = 12, 13, 14, 15; 0 for any other A1.
- No write-to-read bypass; a same-cycle write is visible on the next cycle.
- `EPC_out` always equals EPC; no bypass.

Decomposition:
- Shared package: register numbers (12, 13, 14, 15), field bit positions (IM, EXL, IE, BD, IP, ExcCode) and the ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
- A single flat module; no sub-module.

Test Plan:
- Reset then read: assert reset 1 cycle; A1 = 12/13/14 -> `Dout` = 0; `intreq` = 0; `EPC_out` = 0.
- Write then read back:
  - we=1, A2=12, Din=32'h0000_FC03 -> read A1=12 gives 32'h0000_FC03.
  - we=1, A2=14, Din=32'h0000_3007 -> `EPC_out` = 32'h0000_3004.
  - we=1, A2=13 -> Cause unchanged.
- Hardware interrupt:
  - SR=32'h0000_0401 (IM[10], IE), HW=6'b000001 -> `intreq` = 1.
  - Exlset with PC=30'h0C01 (addr 0x3004), BD=0 -> EPC=0x3004, Cause.ExcCode=0, SR.EXL=1, `intreq` drops to 0.
- Exception in delay slot: SR=0, ExcCode=5'd12 -> `intreq` = 1. Exlset, BD=1, PC addr 0x3010 -> EPC=0x300C, Cause=32'h8000_0030.
- Mask checks and `eret`:
  - IE=0 or IM bit clear with HW active -> `intreq` = 0.
  - EXL=1 with ExcCode=4 -> `intreq` = 0.
  - Exlclr -> EXL=0, `intreq` re-evaluates.
- Simultaneous events:
  - Exlset+we(A2=14, Din=0x1234) -> EPC holds the exception PC.
  - Read A1=15 -> PRID.
  - Read A1=3 -> 0.
